// File: rtl/fpu_share_arbiter.sv
// Purpose: shares one CVFPU among NUM_REQ requesters (RR grant, requester ID in upper FPU tag bits, credit limit per requester).
// Latency: accept in cycle N -> fpu_req_valid in N+1; responses routed back combinationally (0 cycles).
// Backpressure: 1-entry stage refills only when empty or draining; req_ready one-hot on grant; fpu_resp_ready follows resp_ready[id].
// Optional: define FPU_ARB_PERF_CNT_EN to add perf_grants / perf_stall_cycles counters.
module fpu_share_arbiter #(
    parameter  int NUM_REQ         = 4,
    parameter  int WIDTH           = 512,
    parameter  int TAG_WIDTH       = 1,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int ID_W            = $clog2(NUM_REQ),
    localparam int FT_W            = TAG_WIDTH + ID_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_bits_operands_0,
    input  logic [NUM_REQ*WIDTH-1:0]   req_bits_operands_1,
    input  logic [NUM_REQ*WIDTH-1:0]   req_bits_operands_2,
    input  logic [NUM_REQ*3-1:0]       req_bits_roundingMode,
    input  logic [NUM_REQ*5-1:0]       req_bits_op,
    input  logic [NUM_REQ*3-1:0]       req_bits_srcFormat,
    input  logic [NUM_REQ*3-1:0]       req_bits_dstFormat,
    input  logic [NUM_REQ*2-1:0]       req_bits_intFormat,
    input  logic [NUM_REQ*TAG_WIDTH-1:0] req_bits_tag,
    input  logic [NUM_REQ*16-1:0]      req_bits_simdMask,
    output logic [WIDTH-1:0]           fpu_req_bits_operands_0,
    output logic [WIDTH-1:0]           fpu_req_bits_operands_1,
    output logic [WIDTH-1:0]           fpu_req_bits_operands_2,
    output logic [2:0]                 fpu_req_bits_roundingMode,
    output logic [4:0]                 fpu_req_bits_op,
    output logic [2:0]                 fpu_req_bits_srcFormat,
    output logic [2:0]                 fpu_req_bits_dstFormat,
    output logic [1:0]                 fpu_req_bits_intFormat,
    output logic [FT_W-1:0]            fpu_req_bits_tag,
    output logic [15:0]                fpu_req_bits_simdMask,
    output logic                       fpu_req_valid,
    input  logic                       fpu_req_ready,
    output logic                       fpu_flush,
    input  logic [WIDTH-1:0]           fpu_resp_bits_result,
    input  logic [4:0]                 fpu_resp_bits_status,
    input  logic [FT_W-1:0]            fpu_resp_bits_tag,
    input  logic                       fpu_resp_valid,
    output logic                       fpu_resp_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]           resp_bits_result,
    output logic [4:0]                 resp_bits_status,
    output logic [TAG_WIDTH-1:0]       resp_bits_tag,
    input  logic                       flush,
    output logic                       busy
`ifdef FPU_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]      perf_grants,
    output logic [31:0]                perf_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] inc_vec;
    logic [NUM_REQ-1:0] dec_vec;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic               can_load;
    logic               accept;
    logic [ID_W-1:0]    resp_id;
    logic               resp_in_range;
    logic               resp_fire;

    // Eligibility: valid, below credit limit, and no flush/reset in progress.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING)) && !flush && reset_n;
        end
    end

    // Round-robin search starting at ptr; masked requesters are simply skipped.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    assign can_load  = !fpu_req_valid || fpu_req_ready;
    assign accept    = gnt_found && can_load;
    assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
    // Reset also flushes whatever the FPU still has in flight.
    assign fpu_flush = flush || !reset_n;

    // Response routing by the ID field of the returned tag; unknown IDs are dropped.
    always_comb begin
        resp_id        = fpu_resp_bits_tag[TAG_WIDTH +: ID_W];
        resp_in_range  = (32'(resp_id) < NUM_REQ);
        resp_valid     = '0;
        fpu_resp_ready = 1'b1;
        if (resp_in_range) begin
            resp_valid     = NUM_REQ'(fpu_resp_valid) << resp_id;
            fpu_resp_ready = resp_ready[resp_id];
        end
        resp_fire = fpu_resp_valid && fpu_resp_ready && resp_in_range;
    end

    assign resp_bits_result = fpu_resp_bits_result;
    assign resp_bits_status = fpu_resp_bits_status;
    assign resp_bits_tag    = fpu_resp_bits_tag[TAG_WIDTH-1:0];

    // Per-requester credit events and the busy summary.
    always_comb begin
        busy = fpu_req_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            inc_vec[i] = accept && (gnt_idx == ID_W'(i));
            dec_vec[i] = resp_fire && (resp_id == ID_W'(i));
            busy       = busy || (cnt[i] != '0);
        end
    end

    // Stage valid, RR pointer and credit counters; flush empties the stage but keeps ptr.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fpu_req_valid <= 1'b0;
            ptr           <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            if (flush)            fpu_req_valid <= 1'b0;
            else if (accept)      fpu_req_valid <= 1'b1;
            else if (fpu_req_ready) fpu_req_valid <= 1'b0;

            if (accept) begin
                ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush)                                     cnt[i] <= '0;
                else if (inc_vec[i] && !dec_vec[i])            cnt[i] <= cnt[i] + 1'b1;
                else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Stage payload: captured from the granted requester's slice; held while stalled.
    always_ff @(posedge clock) begin
        if (accept) begin
            fpu_req_bits_operands_0   <= req_bits_operands_0[gnt_idx*WIDTH +: WIDTH];
            fpu_req_bits_operands_1   <= req_bits_operands_1[gnt_idx*WIDTH +: WIDTH];
            fpu_req_bits_operands_2   <= req_bits_operands_2[gnt_idx*WIDTH +: WIDTH];
            fpu_req_bits_roundingMode <= req_bits_roundingMode[gnt_idx*3 +: 3];
            fpu_req_bits_op           <= req_bits_op[gnt_idx*5 +: 5];
            fpu_req_bits_srcFormat    <= req_bits_srcFormat[gnt_idx*3 +: 3];
            fpu_req_bits_dstFormat    <= req_bits_dstFormat[gnt_idx*3 +: 3];
            fpu_req_bits_intFormat    <= req_bits_intFormat[gnt_idx*2 +: 2];
            fpu_req_bits_tag          <= {gnt_idx, req_bits_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH]};
            fpu_req_bits_simdMask     <= req_bits_simdMask[gnt_idx*16 +: 16];
        end
    end

`ifdef FPU_ARB_PERF_CNT_EN
    // Grant and stall counters; cleared only by reset, free-running wrap.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_grants       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i]) perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
            end
            if (fpu_req_valid && !fpu_req_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: directed scenario tasks plus a scoreboard that
// checks every request leaving the stage against what was granted, in order.
module tb_fpu_share_arbiter;

    localparam int NR  = 4;
    localparam int W   = 512;
    localparam int TW  = 1;
    localparam int FTW = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset_n;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*W-1:0]   req_bits_operands_0, req_bits_operands_1, req_bits_operands_2;
    logic [NR*3-1:0]   req_bits_roundingMode, req_bits_srcFormat, req_bits_dstFormat;
    logic [NR*5-1:0]   req_bits_op;
    logic [NR*2-1:0]   req_bits_intFormat;
    logic [NR*TW-1:0]  req_bits_tag;
    logic [NR*16-1:0]  req_bits_simdMask;
    logic [W-1:0]      fpu_req_bits_operands_0, fpu_req_bits_operands_1, fpu_req_bits_operands_2;
    logic [2:0]        fpu_req_bits_roundingMode, fpu_req_bits_srcFormat, fpu_req_bits_dstFormat;
    logic [4:0]        fpu_req_bits_op;
    logic [1:0]        fpu_req_bits_intFormat;
    logic [FTW-1:0]    fpu_req_bits_tag;
    logic [15:0]       fpu_req_bits_simdMask;
    logic              fpu_req_valid, fpu_req_ready, fpu_flush;
    logic [W-1:0]      fpu_resp_bits_result;
    logic [4:0]        fpu_resp_bits_status;
    logic [FTW-1:0]    fpu_resp_bits_tag;
    logic              fpu_resp_valid, fpu_resp_ready;
    logic [NR-1:0]     resp_valid, resp_ready;
    logic [W-1:0]      resp_bits_result;
    logic [4:0]        resp_bits_status;
    logic [TW-1:0]     resp_bits_tag;
    logic              flush, busy;
`ifdef FPU_ARB_PERF_CNT_EN
    logic [NR*32-1:0]  perf_grants;
    logic [31:0]       perf_stall_cycles;
`endif

    fpu_share_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bits_operands_0(req_bits_operands_0), .req_bits_operands_1(req_bits_operands_1),
        .req_bits_operands_2(req_bits_operands_2), .req_bits_roundingMode(req_bits_roundingMode),
        .req_bits_op(req_bits_op), .req_bits_srcFormat(req_bits_srcFormat),
        .req_bits_dstFormat(req_bits_dstFormat), .req_bits_intFormat(req_bits_intFormat),
        .req_bits_tag(req_bits_tag), .req_bits_simdMask(req_bits_simdMask),
        .fpu_req_bits_operands_0(fpu_req_bits_operands_0), .fpu_req_bits_operands_1(fpu_req_bits_operands_1),
        .fpu_req_bits_operands_2(fpu_req_bits_operands_2), .fpu_req_bits_roundingMode(fpu_req_bits_roundingMode),
        .fpu_req_bits_op(fpu_req_bits_op), .fpu_req_bits_srcFormat(fpu_req_bits_srcFormat),
        .fpu_req_bits_dstFormat(fpu_req_bits_dstFormat), .fpu_req_bits_intFormat(fpu_req_bits_intFormat),
        .fpu_req_bits_tag(fpu_req_bits_tag), .fpu_req_bits_simdMask(fpu_req_bits_simdMask),
        .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready), .fpu_flush(fpu_flush),
        .fpu_resp_bits_result(fpu_resp_bits_result), .fpu_resp_bits_status(fpu_resp_bits_status),
        .fpu_resp_bits_tag(fpu_resp_bits_tag), .fpu_resp_valid(fpu_resp_valid),
        .fpu_resp_ready(fpu_resp_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bits_result(resp_bits_result), .resp_bits_status(resp_bits_status),
        .resp_bits_tag(resp_bits_tag), .flush(flush), .busy(busy)
`ifdef FPU_ARB_PERF_CNT_EN
        , .perf_grants(perf_grants), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    typedef struct {
        logic [FTW-1:0] tag;
        logic [W-1:0]   op0;
        logic [4:0]     op;
    } exp_t;

    exp_t sb[$];
    exp_t push_e, pop_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic randomize_ops();
        for (int i = 0; i < NR; i++) begin
            for (int w = 0; w < W / 32; w++) begin
                req_bits_operands_0[i*W + w*32 +: 32] = $urandom;
                req_bits_operands_1[i*W + w*32 +: 32] = $urandom;
                req_bits_operands_2[i*W + w*32 +: 32] = $urandom;
            end
            req_bits_roundingMode[i*3 +: 3] = 3'($urandom);
            req_bits_srcFormat[i*3 +: 3]    = 3'($urandom);
            req_bits_dstFormat[i*3 +: 3]    = 3'($urandom);
            req_bits_op[i*5 +: 5]           = 5'($urandom);
            req_bits_intFormat[i*2 +: 2]    = 2'($urandom);
            req_bits_tag[i*TW +: TW]        = TW'($urandom);
            req_bits_simdMask[i*16 +: 16]   = 16'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        randomize_ops();
    endtask

    // Scoreboard: pop on each FPU-side handshake, push on each requester handshake.
    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (fpu_req_valid && fpu_req_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: fpu request tag=%h issued, none expected", fpu_req_bits_tag);
                end else begin
                    pop_e = sb.pop_front();
                    if (fpu_req_bits_tag !== pop_e.tag || fpu_req_bits_operands_0 !== pop_e.op0 ||
                        fpu_req_bits_op !== pop_e.op) begin
                        n_fail++;
                        $display("FAIL sb_data: got tag=%h op=%h op0_lo=%h, want tag=%h op=%h op0_lo=%h",
                                 fpu_req_bits_tag, fpu_req_bits_op, fpu_req_bits_operands_0[31:0],
                                 pop_e.tag, pop_e.op, pop_e.op0[31:0]);
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    push_e.tag = {2'(i), req_bits_tag[i*TW +: TW]};
                    push_e.op0 = req_bits_operands_0[i*W +: W];
                    push_e.op  = req_bits_op[i*5 +: 5];
                    sb.push_back(push_e);
                end
            end
            if (flush) sb.delete();
        end
    end

    task automatic reset_dut();
        reset_n = 1'b0; flush = 1'b0; req_valid = '0; fpu_resp_valid = 1'b0;
        resp_ready = '0; fpu_req_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 4'b1111; fpu_req_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (fpu_flush !== 1'b1) begin n_fail++; $display("FAIL rst_fpu_flush: got %b want 1", fpu_flush); end
            n_checks++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready_low: got %b want 0000", req_ready); end
            tick();
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
        n_checks++;
        if (fpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fpu_req_valid: got %b want 0", fpu_req_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++;
        if (resp_valid !== 4'b0000 || fpu_flush !== 1'b0) begin
            n_fail++; $display("FAIL rst_resp_flush: got resp_valid=%b fpu_flush=%b want 0000/0", resp_valid, fpu_flush);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4];
        exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++;
            if (req_ready !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, exp_g[k]); end
            n_checks++;
            if (fpu_req_valid !== 1'b1) begin n_fail++; $display("FAIL rr_fpu_valid_%0d: got %b want 1", k, fpu_req_valid); end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_single_requester();
        reset_dut();
        req_valid = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            n_checks++;
            if (req_ready !== ((k < 4) ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL single_grant_%0d: got %b want %b", k, req_ready, (k < 4) ? 4'b0100 : 4'b0000);
            end
            n_checks++;
            if (fpu_req_valid !== ((k >= 1 && k <= 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL single_fpu_valid_%0d: got %b", k, fpu_req_valid);
            end
            if (k == 1) begin
                n_checks++;
                if (fpu_req_bits_tag[2:1] !== 2'd2) begin n_fail++; $display("FAIL single_tag_id: got %0d want 2", fpu_req_bits_tag[2:1]); end
            end
            tick();
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_credits: got %b want 1", busy); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        logic [W-1:0]   exp_op0;
        logic [FTW-1:0] exp_tag;
        reset_dut();
        req_valid = 4'b1111; fpu_req_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_first_grant: got %b want 0001", req_ready); end
        exp_op0 = req_bits_operands_0[W-1:0];
        exp_tag = {2'd0, req_bits_tag[0]};
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if (req_ready !== 4'b0000 || fpu_req_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++; $display("FAIL stall_ctrl_%0d: got rdy=%b vld=%b busy=%b want 0000/1/1", k, req_ready, fpu_req_valid, busy);
            end
            n_checks++;
            if (fpu_req_bits_operands_0 !== exp_op0 || fpu_req_bits_tag !== exp_tag) begin
                n_fail++; $display("FAIL stall_hold_%0d: got op0_lo=%h tag=%h want %h/%h", k,
                                   fpu_req_bits_operands_0[31:0], fpu_req_bits_tag, exp_op0[31:0], exp_tag);
            end
            tick();
        end
        fpu_req_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_release_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_credit_limit();
        reset_dut();
        req_valid = 4'b0010; fpu_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++;
            if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL credit_fill_%0d: got %b want 0010", k, req_ready); end
            tick();
        end
        req_valid = 4'b1010;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL credit_mask: got %b want 1000", req_ready); end
        tick();
        fpu_resp_valid = 1'b1; fpu_resp_bits_tag = 3'b010; fpu_resp_bits_status = 5'h3;
        fpu_resp_bits_result = {16{32'hC0DE0001}}; resp_ready = 4'b0010;
        @(negedge clock);
        n_checks++;
        if (resp_valid !== 4'b0010 || fpu_resp_ready !== 1'b1) begin
            n_fail++; $display("FAIL credit_resp_route: got %b/%b want 0010/1", resp_valid, fpu_resp_ready);
        end
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL credit_still_masked: got %b want 1000", req_ready); end
        tick();
        fpu_resp_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL credit_returned: got %b want 0010", req_ready); end
        tick();
        req_valid = '0; resp_ready = '0;
        tick();
    endtask

    task automatic test_resp_routing();
        logic [W-1:0] res;
        reset_dut();
        req_valid = 4'b1000;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL route_setup_grant: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        tick();
        for (int w = 0; w < W / 32; w++) res[w*32 +: 32] = $urandom;
        fpu_resp_valid = 1'b1; fpu_resp_bits_tag = 3'b111; fpu_resp_bits_result = res;
        fpu_resp_bits_status = 5'h15; resp_ready = 4'b0111;
        @(negedge clock);
        n_checks++;
        if (resp_valid !== 4'b1000 || fpu_resp_ready !== 1'b0) begin
            n_fail++; $display("FAIL route_blocked: got %b/%b want 1000/0", resp_valid, fpu_resp_ready);
        end
        n_checks++;
        if (resp_bits_result !== res || resp_bits_status !== 5'h15 || resp_bits_tag !== 1'b1) begin
            n_fail++; $display("FAIL route_payload: got res_lo=%h st=%h tag=%b want %h/15/1",
                               resp_bits_result[31:0], resp_bits_status, resp_bits_tag, res[31:0]);
        end
        tick();
        resp_ready = 4'b1111;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1 || fpu_resp_ready !== 1'b1) begin
            n_fail++; $display("FAIL route_held_credit: got busy=%b rdy=%b want 1/1", busy, fpu_resp_ready);
        end
        tick();
        fpu_resp_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL route_credit_released: got busy=%b want 0", busy); end
        resp_ready = '0;
        tick();
    endtask

    task automatic test_flush();
        logic [3:0] pat [6];
        pat = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0100};
        reset_dut();
        fpu_req_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = pat[k];
            @(negedge clock);
            n_checks++;
            if (req_ready !== pat[k]) begin n_fail++; $display("FAIL flush_setup_%0d: got %b want %b", k, req_ready, pat[k]); end
            tick();
        end
        req_valid = '0; fpu_req_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (fpu_req_valid !== 1'b1 || fpu_req_bits_tag[2:1] !== 2'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre: got vld=%b id=%0d busy=%b want 1/2/1", fpu_req_valid, fpu_req_bits_tag[2:1], busy);
        end
        tick();
        flush = 1'b1; req_valid = 4'b1111;
        @(negedge clock);
        n_checks++;
        if (fpu_flush !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL flush_same_cycle: got fpu_flush=%b rdy=%b want 1/0000", fpu_flush, req_ready);
        end
        tick();
        flush = 1'b0; req_valid = '0;
        @(negedge clock);
        n_checks++;
        if (fpu_req_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_after: got vld=%b busy=%b want 0/0", fpu_req_valid, busy);
        end
        tick();
        req_valid = 4'b1111; fpu_req_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL flush_ptr_kept: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; req_valid = '0; fpu_req_ready = 1'b1;
        fpu_resp_valid = 1'b0; fpu_resp_bits_tag = '0; fpu_resp_bits_status = '0;
        fpu_resp_bits_result = '0; resp_ready = '0;
        randomize_ops();
        #1;
        test_reset();
        test_round_robin();
        test_single_requester();
        test_stall();
        test_credit_limit();
        test_resp_routing();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
